// File: rtl/sprite_rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_pkg
//  Description : Shared sprite geometry, widths, colour key and the sprite
//                ROM address helper for the sprite ROM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

  localparam int SPRITE_DIM = 32;
  localparam int COORD_W    = 5;
  localparam int FRAME_W    = 2;
  localparam int ADDR_W     = 12;
  localparam int PIX_W      = 12;

  localparam logic [PIX_W-1:0] TRANSPARENT_KEY_DEFAULT = 12'hF0F;

  // ROM layout is frame-major, then row, then column. A left-facing fighter
  // reads its row right-to-left so the artwork is stored only once.
  function automatic logic [ADDR_W-1:0] sprite_addr(
    input logic [FRAME_W-1:0] frame,
    input logic [COORD_W-1:0] py,
    input logic [COORD_W-1:0] px,
    input logic               flip
  );
    logic [COORD_W-1:0] col;
    col = flip ? (COORD_W'(SPRITE_DIM - 1) - px) : px;
    return {frame, py, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin grant decode. Purely combinational; the
//                priority pointer is owned by the instantiating block.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  // A lone requester wins outright; on contention the pointer picks the winner.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_ptr ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_rom_arbiter
//  Description : Shares one external sprite ROM between two fighters. Grants
//                one fetch per cycle round-robin, registers the ROM address,
//                and returns the pixel two cycles after the grant tagged with
//                the requester index and a colour-key transparency flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter logic [PIX_W-1:0] TRANSPARENT_KEY = TRANSPARENT_KEY_DEFAULT,
  parameter int               ROM_LATENCY     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req,
  input  logic [COORD_W-1:0] px0,
  input  logic [COORD_W-1:0] py0,
  input  logic [COORD_W-1:0] px1,
  input  logic [COORD_W-1:0] py1,
  input  logic [FRAME_W-1:0] frame0,
  input  logic [FRAME_W-1:0] frame1,
  input  logic               flip0,
  input  logic               flip1,
  output logic [1:0]         gnt,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [PIX_W-1:0]   rom_data,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [PIX_W-1:0]   rsp_pixel,
  output logic               rsp_transparent
);

  // One stage for the address register plus the ROM's own read latency.
  localparam int c_rsp_stages = ROM_LATENCY + 1;

  logic                    r_ptr;
  logic [c_rsp_stages-1:0] r_vld;
  logic [c_rsp_stages-1:0] r_id;
  logic [1:0]              w_arb_gnt;
  logic                    w_grant;
  logic                    w_gnt_idx;
  logic [ADDR_W-1:0]       w_addr;

  rr_arbiter2 u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt)
  );

  // Suppress grants while reset is asserted and select the winner's address.
  always_comb begin
    gnt       = rst_n ? w_arb_gnt : 2'b00;
    w_grant   = |gnt;
    w_gnt_idx = gnt[1];
    w_addr    = w_gnt_idx ? sprite_addr(frame1, py1, px1, flip1)
                          : sprite_addr(frame0, py0, px0, flip0);
  end

  // Pointer and address advance only on a grant; valid/id shift every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr    <= 1'b0;
      rom_addr <= '0;
      r_vld    <= '0;
      r_id     <= '0;
    end else begin
      if (w_grant) begin
        r_ptr    <= ~w_gnt_idx;
        rom_addr <= w_addr;
      end
      r_vld <= {r_vld[c_rsp_stages-2:0], w_grant};
      r_id  <= {r_id[c_rsp_stages-2:0], w_gnt_idx};
    end
  end

  // Pixel comes straight from the ROM; the flag is qualified by valid.
  always_comb begin
    rsp_valid       = r_vld[c_rsp_stages-1];
    rsp_id          = r_id[c_rsp_stages-1];
    rsp_pixel       = rom_data;
    rsp_transparent = rsp_valid && (rom_data == TRANSPARENT_KEY);
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_rom_arbiter
//  Description : Directed self-checking bench for sprite_rom_arbiter with a
//                one-cycle-latency sprite ROM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [4:0]  px0, py0, px1, py1;
  logic [1:0]  frame0, frame1;
  logic        flip0, flip1;
  logic [1:0]  gnt;
  logic [11:0] rom_addr;
  logic [11:0] rom_data;
  logic        rsp_valid;
  logic        rsp_id;
  logic [11:0] rsp_pixel;
  logic        rsp_transparent;

  logic [11:0] mem [0:4095];

  int n_tests = 0;
  int n_fail  = 0;

  sprite_rom_arbiter #(
    .TRANSPARENT_KEY (12'hF0F),
    .ROM_LATENCY     (1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .px0             (px0),
    .py0             (py0),
    .px1             (px1),
    .py1             (py1),
    .frame0          (frame0),
    .frame1          (frame1),
    .flip0           (flip0),
    .flip1           (flip1),
    .gnt             (gnt),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .rsp_valid       (rsp_valid),
    .rsp_id          (rsp_id),
    .rsp_pixel       (rsp_pixel),
    .rsp_transparent (rsp_transparent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: one cycle from address to data.
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 12'(i) ^ 12'h0A5;
    mem[12'h443] = 12'hF0F;
    mem[12'h01C] = 12'hF0E;

    // Reset with both requests asserted: no grant may escape.
    rst_n = 1'b0; req = 2'b11;
    px0 = '0; py0 = '0; px1 = '0; py1 = '0;
    frame0 = '0; frame1 = '0; flip0 = 1'b0; flip1 = 1'b0;
    repeat (3) tick;
    check_eq("rst_gnt",   32'(gnt),             32'h0);
    check_eq("rst_addr",  32'(rom_addr),        32'h0);
    check_eq("rst_valid", 32'(rsp_valid),       32'h0);
    check_eq("rst_id",    32'(rsp_id),          32'h0);
    check_eq("rst_transp",32'(rsp_transparent), 32'h0);

    // Requester 0 alone, frame 1 row 2 col 3 -> 0x443, ROM returns the key.
    rst_n = 1'b1; req = 2'b01; px0 = 5'd3; py0 = 5'd2; frame0 = 2'd1; flip0 = 1'b0;
    #1 check_eq("r0_gnt", 32'(gnt), 32'h1);
    tick; req = 2'b00; #1;
    check_eq("r0_addr",     32'(rom_addr),  32'h443);
    check_eq("r0_valid_T1", 32'(rsp_valid), 32'h0);
    tick;
    check_eq("r0_valid",  32'(rsp_valid),       32'h1);
    check_eq("r0_id",     32'(rsp_id),          32'h0);
    check_eq("r0_pixel",  32'(rsp_pixel),       32'hF0F);
    check_eq("r0_transp", 32'(rsp_transparent), 32'h1);

    // Requester 1 alone, mirrored col 3 -> col 28 -> 0x01C, pixel one off key.
    req = 2'b10; px1 = 5'd3; py1 = 5'd0; frame1 = 2'd0; flip1 = 1'b1;
    #1 check_eq("r1_gnt", 32'(gnt), 32'h2);
    tick; req = 2'b00; #1;
    check_eq("r1_addr", 32'(rom_addr), 32'h01C);
    tick;
    check_eq("r1_valid",  32'(rsp_valid),       32'h1);
    check_eq("r1_id",     32'(rsp_id),          32'h1);
    check_eq("r1_pixel",  32'(rsp_pixel),       32'hF0E);
    check_eq("r1_transp", 32'(rsp_transparent), 32'h0);

    // Requester 0: frame 2 row 7 mirrored col 5 -> col 26 -> 0x8FA; leaves pointer at 1.
    req = 2'b01; px0 = 5'd5; py0 = 5'd7; frame0 = 2'd2; flip0 = 1'b1;
    #1 check_eq("r0b_gnt", 32'(gnt), 32'h1);
    tick; req = 2'b00; #1;
    check_eq("r0b_addr", 32'(rom_addr), 32'h8FA);
    tick;
    check_eq("r0b_valid", 32'(rsp_valid), 32'h1);
    check_eq("r0b_id",    32'(rsp_id),    32'h0);
    check_eq("r0b_pixel", 32'(rsp_pixel), 32'h85F);

    // Five idle cycles: nothing valid, address held.
    for (int i = 0; i < 5; i++) begin
      tick;
      check_eq("idle_valid",  32'(rsp_valid),       32'h0);
      check_eq("idle_transp", 32'(rsp_transparent), 32'h0);
      check_eq("idle_addr",   32'(rom_addr),        32'h8FA);
    end

    // Pointer still names requester 1 after idling.
    req = 2'b11;
    #1 check_eq("ptr_after_idle", 32'(gnt), 32'h2);
    // Pointer now names requester 0, yet a lone requester 1 is granted.
    tick; req = 2'b10;
    #1 check_eq("single_vs_ptr", 32'(gnt), 32'h2);
    tick; req = 2'b00;
    tick; tick;

    // Fresh reset, then both held six cycles: strict alternation from 0.
    rst_n = 1'b0; tick; tick;
    rst_n = 1'b1;
    px0 = 5'd2; py0 = 5'd1;  frame0 = 2'd0; flip0 = 1'b0;  // 0x022
    px1 = 5'd0; py1 = 5'd31; frame1 = 2'd3; flip1 = 1'b1;  // 0xFFF
    req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      int k;
      if (i == 6) req = 2'b00;
      #1;
      check_eq("rr_gnt", 32'(gnt), (i < 6) ? ((i % 2) ? 32'h2 : 32'h1) : 32'h0);
      if (i >= 1) begin
        k = (i < 6) ? i : 6;
        check_eq("rr_addr", 32'(rom_addr), ((k - 1) % 2) ? 32'hFFF : 32'h022);
      end
      if (i >= 2) begin
        check_eq("rr_valid", 32'(rsp_valid), 32'h1);
        check_eq("rr_id",    32'(rsp_id),    32'((i - 2) % 2));
        check_eq("rr_pixel", 32'(rsp_pixel), ((i - 2) % 2) ? 32'hF5A : 32'h087);
      end
      tick;
    end
    check_eq("rr_drain_valid", 32'(rsp_valid), 32'h0);

    // Grants in T and T+1 with reset in T+1: both fetches dropped.
    req = 2'b01; px0 = 5'd3; py0 = 5'd2; frame0 = 2'd1; flip0 = 1'b0;
    #1 check_eq("abort_gnt_T", 32'(gnt), 32'h1);
    tick; req = 2'b10; rst_n = 1'b0;
    #1 check_eq("abort_gnt_rst", 32'(gnt), 32'h0);
    tick; rst_n = 1'b1; req = 2'b00;
    #1;
    check_eq("abort_valid_T2", 32'(rsp_valid), 32'h0);
    check_eq("abort_addr",     32'(rom_addr),  32'h0);
    tick;
    check_eq("abort_valid_T3", 32'(rsp_valid), 32'h0);
    req = 2'b11;
    #1 check_eq("abort_ptr", 32'(gnt), 32'h1);
    tick; req = 2'b00;
    tick; tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter TRANSPARENT_KEY, default 12'hF0F, is the colour-key value flagged as transparent.
REQ-002 Parameter ROM_LATENCY, default 1, is the cycles from ROM address register to valid pixel_data; only value 1 is supported.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 req  input  2  per-fighter fetch request; bit 0 = player 1, bit 1 = player 2.
REQ-006 px0, py0 / px1, py1  input  5 each  pixel column/row within the 32x32 sprite for requester 0/1.
REQ-007 frame0 / frame1  input  2 each  animation frame select (0-3) for requester 0/1.
REQ-008 flip0 / flip1  input  1 each  horizontal mirror (fighter facing left) for requester 0/1.
REQ-009 gnt  output  2  one-hot grant, at most one bit high per cycle.
REQ-010 rom_addr  output  12  registered address driven to the sprite ROM addr port.
REQ-011 rom_data  input  12  sprite ROM pixel_data output.
REQ-012 rsp_valid  output  1  response pixel valid.
REQ-013 rsp_id  output  1  requester index the response belongs to.
REQ-014 rsp_pixel  output  12  RGB pixel, equal to rom_data while rsp_valid is high.
REQ-015 rsp_transparent  output  1  high when rsp_valid and rsp_pixel == TRANSPARENT_KEY.

Function
REQ-016 gnt SHALL be combinational from req and the registered priority pointer; a request is accepted in the cycle its gnt bit is high.
REQ-017 Requesters SHALL hold req and operands stable until granted; operands are sampled only in the grant cycle.
REQ-018 Single request SHALL be granted immediately regardless of pointer; no request -> gnt = 2'b00.
REQ-019 Both requesting SHALL grant the requester named by the pointer; the pointer SHALL then move to the other requester (round-robin).
REQ-020 The pointer SHALL update only on a grant; idle cycles leave it unchanged.
REQ-021 Address SHALL be {frame, py, flip ? (31 - px) : px}; 12 bits, no overflow possible.
REQ-022 rom_addr SHALL load on the posedge ending the grant cycle and hold its value when no grant occurs.
REQ-023 A grant in cycle T SHALL produce rsp_valid = 1 in cycle T+2 with rsp_id = granted index; the pipeline is two valid/id stages.
REQ-024 Throughput SHALL be one grant per cycle; back-to-back grants yield back-to-back responses in grant order.
REQ-025 rsp_valid SHALL be 0 in any cycle with no grant two cycles earlier; rsp_transparent is 0 whenever rsp_valid is 0.
REQ-026 Starvation bound: with both requests held, each requester SHALL be granted at least once every 2 cycles.

Reset
REQ-027 While rst_n = 0 at a clock edge: pointer <= 0 (requester 0 priority), rom_addr <= 0, both valid stages <= 0, rsp_id <= 0.
REQ-028 gnt SHALL be 2'b00 in every cycle rst_n is low.
REQ-029 Reset mid-operation SHALL discard in-flight fetches; no rsp_valid for grants issued in the two cycles before reset.

Structure
REQ-030 Package sprite_pkg SHALL hold SPRITE_DIM = 32, ADDR_W = 12, PIX_W = 12, FRAME_W = 2 and the default TRANSPARENT_KEY.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arbiter2 (req, pointer in; gnt out); pointer register stays in the parent.
REQ-032 The ROM itself is external; the block instantiates no memory.

Verification
REQ-033 Reset then req = 2'b01, px0 = 3, py0 = 2, frame0 = 1, flip0 = 0 -> gnt = 01 same cycle, rom_addr = 12'h443, rsp_valid/rsp_id = 1/0 two cycles later.
REQ-034 req = 2'b10, px1 = 3, py1 = 0, frame1 = 0, flip1 = 1 -> rom_addr = 12'h01C.
REQ-035 req = 2'b11 held 6 cycles after reset -> gnt sequence 01,10,01,10,01,10; rsp_id sequence 0,1,0,1,0,1 delayed 2 cycles.
REQ-036 ROM model returning 12'hF0F at the granted address -> rsp_transparent = 1; returning 12'hF0E -> 0.
REQ-037 Grants in cycles T and T+1, rst_n low in cycle T+1 -> no rsp_valid in T+2 or T+3, pointer = 0 after reset.
REQ-038 Idle 5 cycles between single grants -> pointer unchanged, rom_addr holds last value, rsp_valid low during idle.
